// File: rtl/div_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// div_seq_ctrl_pkg
// Shared definitions for the sequential non-restoring divide unit.
//   DIV_WIDTH : default operand/quotient/remainder width
//   state_t   : controller state encoding
// Optional build macro used by the divider: DIV_SIGNED_EN (two's complement
// operands); when undefined the unit is unsigned only.
// -----------------------------------------------------------------------------
package div_seq_ctrl_pkg;

    localparam int DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/div_seq_ctrl_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational non-restoring division iteration.
//   a_in  : signed partial remainder (WIDTH+1 bits)
//   q_in  : quotient / dividend shift register (WIDTH bits)
//   m_in  : unsigned divisor (WIDTH bits, zero-extended internally)
//   a_out : next partial remainder
//   q_out : next quotient register, new bit shifted into LSB
// -----------------------------------------------------------------------------
module div_step
    import div_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic signed [WIDTH:0]   a_in,
    input  logic        [WIDTH-1:0] q_in,
    input  logic        [WIDTH-1:0] m_in,
    output logic signed [WIDTH:0]   a_out,
    output logic        [WIDTH-1:0] q_out
);

    logic signed [WIDTH:0] a_sh;
    logic signed [WIDTH:0] m_ext;

    always_comb begin
        // {A,Q} << 1: the old sign bit of A falls off, but it still selects
        // the operation. The true result lies in [-M, M), so the modulo
        // 2^(WIDTH+1) arithmetic is exact even for divisors with MSB set.
        a_sh  = {a_in[WIDTH-1:0], q_in[WIDTH-1]};
        m_ext = $signed({1'b0, m_in});
        if (a_in[WIDTH]) begin
            a_out = a_sh + m_ext;
        end else begin
            a_out = a_sh - m_ext;
        end
        q_out = {q_in[WIDTH-2:0], ~a_out[WIDTH]};
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// div_seq_ctrl
// Multi-cycle divide unit: one non-restoring step per clock for WIDTH cycles,
// one remainder-correction cycle, then a one-cycle done pulse.
//   clk, rst            : clock, asynchronous active-high reset
//   start               : request, sampled only in IDLE
//   dividend, divisor   : operands captured on an accepted start
//   busy                : high from the cycle after accept through done
//   done                : one-cycle result-valid pulse
//   quotient, remainder : results, held until the next result is loaded
//   div_zero            : divisor was zero (quotient all-ones, rem=dividend)
// Build option: define DIV_SIGNED_EN for two's complement operands
// (truncating quotient, remainder carries the dividend's sign).
// -----------------------------------------------------------------------------
module div_seq_ctrl
    import div_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t                state_q,  state_d;
    logic signed [WIDTH:0] a_q,      a_d;
    logic [WIDTH-1:0]      q_q,      q_d;
    logic [WIDTH-1:0]      m_q,      m_d;
    logic [CW-1:0]         cnt_q,    cnt_d;
    logic [WIDTH-1:0]      quot_q,   quot_d;
    logic [WIDTH-1:0]      rem_q,    rem_d;
    logic                  dz_q,     dz_d;

    logic signed [WIDTH:0] step_a;
    logic [WIDTH-1:0]      step_q;
    logic signed [WIDTH:0] a_fix;

`ifdef DIV_SIGNED_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v,
                                                 input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .a_in  (a_q),
        .q_in  (q_q),
        .m_in  (m_q),
        .a_out (step_a),
        .q_out (step_q)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
`ifdef DIV_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        // Final correction: a negative partial remainder is restored once.
        a_fix = a_q[WIDTH] ? (a_q + $signed({1'b0, m_q})) : a_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        dz_d    = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        a_d     = '0;
                        cnt_d   = '0;
`ifdef DIV_SIGNED_EN
                        // Divide magnitudes; the most-negative value's
                        // magnitude still fits as an unsigned WIDTH-bit word.
                        q_d     = neg_if(dividend, dividend[WIDTH-1]);
                        m_d     = neg_if(divisor,  divisor[WIDTH-1]);
                        qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        rneg_d  = dividend[WIDTH-1];
`else
                        q_d     = dividend;
                        m_d     = divisor;
`endif
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                a_d   = step_a;
                q_d   = step_q;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                a_d     = a_fix;
`ifdef DIV_SIGNED_EN
                quot_d  = neg_if(q_q, qneg_q);
                rem_d   = neg_if(a_fix[WIDTH-1:0], rneg_q);
`else
                quot_d  = q_q;
                rem_d   = a_fix[WIDTH-1:0];
`endif
                dz_d    = 1'b0;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
`ifdef DIV_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
`ifdef DIV_SIGNED_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_seq_ctrl
// Directed bench for div_seq_ctrl (WIDTH=8). Expected results are pushed to a
// scoreboard queue when an operation is launched and popped by a monitor on
// each done pulse. Define DIV_SIGNED_EN to exercise the signed build.
// -----------------------------------------------------------------------------
module tb_div_seq_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] quotient, remainder;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;

    div_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   sa, sb;
        if (b == '0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            sa = int'($signed(a));
            sb = int'($signed(b));
`else
            sa = int'(a);
            sb = int'(b);
`endif
            e.q  = W'(sa / sb);
            e.r  = W'(sa % sb);
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            done_cnt++;
            if (sb_q.size() == 0) begin
                chk("spurious_done", 32'(done), 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("quotient",  32'(quotient),  32'(e.q));
                chk("remainder", 32'(remainder), 32'(e.r));
                chk("div_zero",  32'(div_zero),  32'(e.dz));
            end
        end
    end

    // Launch one operation (called just after a negedge), measure latency and
    // busy duration, scramble the inputs once captured.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int exp_lat, input string tag);
        int lat = 0;
        int busy_n = 0;
        bit seen = 0;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb_q.push_back(model(a, b));
        while (!seen && lat < 40) begin
            @(negedge clk);
            if (lat == 0) begin
                start    = 1'b0;
                dividend = W'($urandom);
                divisor  = W'($urandom);
            end
            lat++;
            if (busy) busy_n++;
            if (done) seen = 1;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat));
        @(negedge clk);
        chk({tag, "_idle_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int d0;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quot", 32'(quotient), 32'd0);
        chk("rst_rem",  32'(remainder), 32'd0);
        chk("rst_dz",   32'(div_zero), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(8'd100, 8'd7,   W + 2, "u100_7");
        run_op(8'd255, 8'd1,   W + 2, "u255_1");
        run_op(8'd200, 8'd200, W + 2, "u200_200");
        run_op(8'd3,   8'd250, W + 2, "u3_250");
        run_op(8'd255, 8'd128, W + 2, "u255_128");

        // Divide by zero, then flag holds until the next result
        run_op(8'd5, 8'd0, 1, "dz5_0");
        repeat (3) @(negedge clk);
        chk("dz_held", 32'(div_zero), 32'd1);
        run_op(8'd9, 8'd3, W + 2, "u9_3");

        // Re-pulsed start during RUN is ignored
        d0 = done_cnt;
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        sb_q.push_back(model(8'd100, 8'd7));
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        dividend = 8'd50;
        divisor  = 8'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (25) @(negedge clk);
        chk("repulse_one_done", 32'(done_cnt - d0), 32'd1);

        // Reset in the middle of an operation
        d0 = done_cnt;
        dividend = 8'd77;
        divisor  = 8'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_quot", 32'(quotient), 32'd0);
        chk("mid_rst_rem",  32'(remainder), 32'd0);
        chk("mid_rst_dz",   32'(div_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        run_op(8'd81, 8'd9, W + 2, "u81_9");

`ifdef DIV_SIGNED_EN
        run_op(8'h9C, 8'h07, W + 2, "sm100_7");
        run_op(8'h64, 8'hF9, W + 2, "s100_m7");
        run_op(8'h80, 8'hFF, W + 2, "sm128_m1");
        run_op(8'hFB, 8'h00, 1,     "sdz");
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
